// File: rtl/counter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_ctrl : clear/enable sequencer for an external bit-slice counter.
// Optional macro COUNTER_CTRL_PERIOD_CNT_EN builds the period counter. Rev 1.0
// ---------------------------------------------------------------------------
module counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_periodic,
  input  logic [WIDTH-1:0] terminal,
  input  logic [WIDTH-1:0] count_value,
  output logic             count_clear,
  output logic             count_enable,
  output logic             busy,
  output logic             done,
  output logic [7:0]       period_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] term_q;
  logic             accept_start;
  logic             detect;
  logic             finish;

  assign accept_start = (state == IDLE) && start && !stop;
  assign detect       = (state == RUN) && (count_value == term_q);
  // stop outranks a terminal detect in the same cycle
  assign finish       = detect && !stop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      term_q <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= finish;
      if (accept_start) begin
        term_q <= terminal;
      end
    end
  end

  always_comb begin
    state_next   = state;
    count_clear  = 1'b0;
    count_enable = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (accept_start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        busy        = 1'b1;
        count_clear = 1'b1;
        state_next  = stop ? IDLE : RUN;
      end
      RUN: begin
        busy         = 1'b1;
        count_enable = (count_value != term_q);
        if (stop) begin
          state_next = IDLE;
        end else if (detect) begin
          state_next = mode_periodic ? CLEAR : DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef COUNTER_CTRL_PERIOD_CNT_EN
  logic [7:0] period_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_q <= 8'd0;
    end else if (accept_start) begin
      period_q <= 8'd0;
    end else if (finish && (period_q != 8'hFF)) begin
      period_q <= period_q + 8'd1;
    end
  end

  assign period_cnt = period_q;
`else
  assign period_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencing controller for the ripple-carry bit-slice counter datapath (full adder + D flip-flop per bit). Clears the counter, gates its increment enable until a programmable terminal value is reached, and reports completion. Supports one-shot and periodic (auto-reload) modes. The counter stays an external datapath; this block only drives its clear and enable inputs and observes its value.

Parameters:
WIDTH, 4, counter datapath width in bits; also the width of the terminal and count_value ports.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  level, sampled each edge; begins a run from IDLE.
stop  input  1  level, sampled each edge; aborts any run.
mode_periodic  input  1  0 = one-shot, 1 = auto-restart after each terminal; sampled at terminal detect.
terminal  input  WIDTH  terminal count; latched into term_q on an accepted start.
count_value  input  WIDTH  current counter datapath value.
count_clear  output  1  synchronous clear request to the datapath.
count_enable  output  1  increment enable to the datapath.
busy  output  1  high in every state except IDLE.
done  output  1  registered one-cycle pulse per terminal reached.
period_cnt  output  8  completed periods since last start; see Optional Feature.

Behaviour:
- Datapath contract: count_clear=1 forces the counter to 0 at the next edge. count_enable=1 adds 1 mod 2^WIDTH at the next edge. Clear wins over enable.
- Reset (reset=0, asynchronous): state=IDLE, term_q=0, done=0, period_cnt=0. count_clear, count_enable and busy go to 0 immediately. Reset mid-run abandons the run with no done pulse.
- States: IDLE, CLEAR, RUN, DONE. Encoding is free.
- IDLE: outputs 0. start=1 and stop=0 -> latch term_q<=terminal, period_cnt<=0, go to CLEAR.
- CLEAR: count_clear=1 and count_enable=0 for exactly one cycle -> RUN.
- RUN: count_enable = (count_value != term_q), combinational. When count_value == term_q (terminal detect):
  - done<=1 for the next cycle; period_cnt increments, saturating at 255.
  - mode_periodic=1 -> CLEAR. mode_periodic=0 -> DONE.
- DONE: one cycle, all enables 0 -> IDLE. done is high during this cycle.
- Latency from the start-sampling edge E0: CLEAR after E0; RUN after E1 with count 0; detect in the cycle after E(1+T); done high after E(2+T). count_enable is high for exactly T cycles per period. Periodic period is T+2 cycles.
- terminal=0: detect in the first RUN cycle; count_enable never asserts; done follows CLEAR by 2 cycles.
- terminal=2^WIDTH-1: full range, no special case.
- stop=1 in CLEAR, RUN or DONE -> IDLE at the next edge, no done pulse, period_cnt holds. stop beats start and beats terminal detect in the same cycle.
- start while busy is ignored, with no restart. term_q is fixed for the whole run, including all periodic periods. Changes to terminal during a run have no effect.
- A mode_periodic change mid-run takes effect at the next terminal detect.
- If count_value is already past term_q (datapath mismatch), enable stays high; the counter wraps and detect occurs on equality. No error flag.

Optional Feature:
COUNTER_CTRL_PERIOD_CNT_EN:
- Defined: the period_cnt register exists with the behaviour above.
- Undefined: the register is not built and period_cnt is tied to 0. All other behaviour is identical.

Test Plan:
- One-shot, WIDTH=4, terminal=5, single-cycle start at E0 -> count_clear high 1 cycle; count_enable high 5 consecutive cycles; done high exactly once, in the cycle after E7; busy low after E8; count_value holds at 5.
- Periodic, terminal=3, run 3 periods, then stop -> done pulses spaced exactly 5 cycles apart; period_cnt=3 (with the macro defined) or 0 (without); after stop, busy=0 with no extra done pulse.
- terminal=0, one-shot -> count_enable never high; done high 2 cycles after the CLEAR cycle.
- Run with terminal=9; stop asserted when count_value=4 -> IDLE next edge; count_enable drops; done never asserts; a new start with terminal=2 completes normally.
- Start held high, with terminal changed from 6 to 1 mid-run -> no restart; detect at 6; done once; then a new run begins from IDLE because start is still high.
- reset pulled low mid-RUN at count_value=3 -> count_enable and busy drop without waiting for a clock edge; after release, state is IDLE and done=0.
